aes_perf_sampler: RTL and testbench
===================================

AES_PERF_SAMPLER -- requirements
Module: aes_perf_sampler

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning sample FIFO depth (power of 2, 2..64).
REQ-002 SHALL have parameter CTR_BASE, default 0, meaning counter section base word address in the perf-counter slave (0 or 4).
REQ-003 SHALL have port clk, input, 1, system clock.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port aes_start, input, 1, single-cycle pulse when an AES operation begins.
REQ-006 SHALL have port aes_done, input, 1, single-cycle pulse when an AES operation completes.
REQ-007 SHALL have ports m_address (output, 3), m_write (output, 1), m_begintransfer (output, 1), m_writedata (output, 32) and m_readdata (input, 32), forming the Avalon-MM master to the perf-counter slave; m_readdata is valid one cycle after m_address is driven.
REQ-008 SHALL have ports s_address (input, 3), s_read (input, 1), s_write (input, 1), s_writedata (input, 32) and s_readdata (output, 32), forming the CPU Avalon-MM slave.

Function
REQ-009 FSM states SHALL be IDLE, GO, RUN, STOP, RD_LO, RD_HI, CAP and PUSH, plus EVT when the event feature is enabled.
REQ-010 IDLE->GO SHALL occur on aes_start while CTRL.enable=1; in GO the block SHALL drive m_write=m_begintransfer=1, m_address=CTR_BASE+1 and m_writedata=0 for exactly one cycle, then enter RUN.
REQ-011 RUN->STOP SHALL occur on aes_done; in STOP the block SHALL drive a one-cycle write to CTR_BASE+0 with m_writedata=0.
REQ-012 In RD_LO the block SHALL drive m_address=CTR_BASE. In RD_HI it SHALL drive CTR_BASE+1 and latch m_readdata as lo. In CAP it SHALL latch m_readdata as hi. PUSH SHALL then write {hi,lo} into the FIFO and return to IDLE.
REQ-013 Outside write cycles, m_write and m_begintransfer SHALL be 0; m_address SHALL hold its last value when no read is in progress.
REQ-014 aes_start in any state other than IDLE SHALL be ignored and SHALL increment an 8-bit saturating drop_cnt.
REQ-015 aes_done outside RUN SHALL be ignored.
REQ-016 If aes_start and aes_done are asserted in the same IDLE cycle, the block SHALL take start only.
REQ-017 A PUSH while the FIFO is full SHALL discard the sample and set sticky overflow; FIFO contents SHALL be unchanged.
REQ-018 CPU register 0, STATUS (read-only), SHALL be laid out as: [7:0] fifo count, [8] empty, [9] full, [10] overflow, [11] busy (state!=IDLE), [23:16] drop_cnt.
REQ-019 CPU register 1 SHALL return the head sample lo. Register 2 SHALL return the head sample hi and pop the head on read. Reading either register while the FIFO is empty SHALL return 0 with no pop.
REQ-020 CPU register 3, CTRL, SHALL be laid out as: [0] enable (R/W), [1] clear FIFO, overflow and drop_cnt (write-1 pulse), [2] counter clear request (write-1).
REQ-021 A counter clear request SHALL be executed in IDLE only, as a one-cycle write to CTR_BASE+0 with m_writedata=1; a request made while busy SHALL stay pending until IDLE and take priority over aes_start in that cycle.
REQ-022 s_readdata SHALL be registered, with 1-cycle read latency.
REQ-023 Simultaneous pop and PUSH SHALL keep count unchanged and be legal when the FIFO is full.
REQ-024 Clearing enable mid-operation SHALL NOT abort the FSM; the sequence in progress SHALL complete.

Reset
REQ-025 On reset_n=0, the block SHALL set: state IDLE, FIFO empty, overflow=0, drop_cnt=0, enable=0, pending clear=0, all m_* outputs=0, s_readdata=0.
REQ-026 Reset asserted mid-sequence SHALL abandon the sequence; no partial sample SHALL be pushed.

Configuration
REQ-027 With AES_PERF_SAMPLER_EVENT_EN defined, the FSM SHALL insert state EVT after CAP, driving m_address=CTR_BASE+2 and latching the event count the following cycle; the FIFO width SHALL be 96 bits; CPU register 4 SHALL return the head event count (no pop), and it must be read before register 2.
REQ-028 Without AES_PERF_SAMPLER_EVENT_EN, there SHALL be no EVT state, FIFO width SHALL be 64 bits, and register 4 SHALL read 0.

Verification
REQ-029 Bench SHALL cover: enable=1; start, done 100 cycles later; model counter -> GO write addr 1 and STOP write addr 0 each seen once, FIFO count=1, reg1 reads measured duration (~100), reg2 reads 0, count returns to 0.
REQ-030 Bench SHALL cover: aes_start pulsed 3 times during RUN -> drop_cnt=3, one sample only.
REQ-031 Bench SHALL cover: DEPTH=8, 9 operations without popping -> full=1, overflow=1, count=8, first 8 samples intact.
REQ-032 Bench SHALL cover: CTRL write 0x5 while in RUN -> clear write (addr 0, data 1) issued only after return to IDLE, before the next GO.
REQ-033 Bench SHALL cover: reset_n asserted in RD_HI -> all outputs 0, FIFO empty, no push after release.
REQ-034 Bench SHALL cover: CTR_BASE=4 with AES_PERF_SAMPLER_EVENT_EN defined -> writes to addresses 5 and 4, reads of 4, 5 and 6, reg4 returns event count 1.

Source files
------------

// File: rtl/aes_perf_sampler.sv
// aes_perf_sampler: times AES operations via an external perf-counter slave
// and queues {hi,lo} samples for the CPU. Option: AES_PERF_SAMPLER_EVENT_EN.
module aes_perf_sampler #(
   parameter int DEPTH    = 8,
   parameter int CTR_BASE = 0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        aes_start,
   input  logic        aes_done,
   output logic [2:0]  m_address,
   output logic        m_write,
   output logic        m_begintransfer,
   output logic [31:0] m_writedata,
   input  logic [31:0] m_readdata,
   input  logic [2:0]  s_address,
   input  logic        s_read,
   input  logic        s_write,
   input  logic [31:0] s_writedata,
   output logic [31:0] s_readdata
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [2:0] A_CTL = 3'(CTR_BASE);
   localparam logic [2:0] A_HI  = 3'(CTR_BASE + 1);
`ifdef AES_PERF_SAMPLER_EVENT_EN
   localparam int FW = 96;
   localparam logic [2:0] A_EVT = 3'(CTR_BASE + 2);
   typedef enum logic [3:0] {
      IDLE, GO, RUN, STOP, RD_LO, RD_HI, CAP, PUSH, EVT
   } state_t;
`else
   localparam int FW = 64;
   typedef enum logic [3:0] {
      IDLE, GO, RUN, STOP, RD_LO, RD_HI, CAP, PUSH
   } state_t;
`endif

   state_t state, state_nxt;

   logic          enable, clr_pend, overflow;
   logic [7:0]    drop_cnt;
   logic [31:0]   lo_q, hi_q;
   logic [FW-1:0] mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [CW-1:0] count;
   logic          empty, full, push, pop, wr_en;
   logic          ctrl_wr, fifo_clr, busy;
   logic [FW-1:0] head, sample;
   logic [31:0]   status, rd_evt;
   logic          clr_fire, wr_nxt;
   logic [2:0]    addr_nxt;
   logic [31:0]   wdata_nxt;
   logic          unused_wdata;

   assign ctrl_wr  = s_write && (s_address == 3'd3);
   assign fifo_clr = ctrl_wr && s_writedata[1];
   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign pop      = s_read && (s_address == 3'd2) && !empty;
   assign push     = (state == PUSH);
   assign wr_en    = push && (!full || pop) && !fifo_clr;
   assign busy     = (state != IDLE);
   assign head     = mem[rptr];
   assign status   = {8'h0, drop_cnt, 4'h0, busy, overflow,
                      full, empty, 8'(count)};
   assign unused_wdata = ^s_writedata[31:3];

`ifdef AES_PERF_SAMPLER_EVENT_EN
   assign sample = {m_readdata, hi_q, lo_q};
   assign rd_evt = empty ? 32'h0 : head[95:64];
`else
   assign sample = {hi_q, lo_q};
   assign rd_evt = 32'h0;
`endif

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next state, plus the master command to present with that state
   always_comb begin
      state_nxt = state;
      clr_fire  = 1'b0;
      unique case (state)
         IDLE: begin
            if (clr_pend)
               clr_fire = 1'b1;
            else if (aes_start && enable)
               state_nxt = GO;
         end
         GO:    state_nxt = RUN;
         RUN:   if (aes_done) state_nxt = STOP;
         STOP:  state_nxt = RD_LO;
         RD_LO: state_nxt = RD_HI;
         RD_HI: state_nxt = CAP;
`ifdef AES_PERF_SAMPLER_EVENT_EN
         CAP:   state_nxt = EVT;
         EVT:   state_nxt = PUSH;
`else
         CAP:   state_nxt = PUSH;
`endif
         PUSH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      wr_nxt    = 1'b0;
      addr_nxt  = m_address;
      wdata_nxt = 32'h0;
      unique case (state_nxt)
         GO: begin
            wr_nxt   = 1'b1;
            addr_nxt = A_HI;
         end
         STOP: begin
            wr_nxt   = 1'b1;
            addr_nxt = A_CTL;
         end
         RD_LO: addr_nxt = A_CTL;
         RD_HI: addr_nxt = A_HI;
`ifdef AES_PERF_SAMPLER_EVENT_EN
         EVT:   addr_nxt = A_EVT;
`endif
         default: ;
      endcase
      if (clr_fire) begin
         wr_nxt    = 1'b1;
         addr_nxt  = A_CTL;
         wdata_nxt = 32'h1;
      end
   end

   // Registered master outputs; address holds between accesses
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_address       <= 3'h0;
         m_write         <= 1'b0;
         m_begintransfer <= 1'b0;
         m_writedata     <= 32'h0;
      end else begin
         m_address       <= addr_nxt;
         m_write         <= wr_nxt;
         m_begintransfer <= wr_nxt;
         m_writedata     <= wdata_nxt;
      end
   end

   // Capture counter words as they return from the slave
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lo_q <= 32'h0;
         hi_q <= 32'h0;
      end else begin
         if (state == RD_HI) lo_q <= m_readdata;
         if (state == CAP)   hi_q <= m_readdata;
      end
   end

   // Control register, pending counter clear, drop and overflow tracking
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         enable   <= 1'b0;
         clr_pend <= 1'b0;
         drop_cnt <= 8'h0;
         overflow <= 1'b0;
      end else begin
         if (ctrl_wr) enable <= s_writedata[0];
         if (ctrl_wr && s_writedata[2]) clr_pend <= 1'b1;
         else if (clr_fire)             clr_pend <= 1'b0;
         if (fifo_clr)
            drop_cnt <= 8'h0;
         else if (aes_start && busy && drop_cnt != 8'hff)
            drop_cnt <= drop_cnt + 8'd1;
         if (fifo_clr)
            overflow <= 1'b0;
         else if (push && full && !pop)
            overflow <= 1'b1;
      end
   end

   // Sample storage
   always_ff @(posedge clk) begin
      if (wr_en) mem[wptr] <= sample;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (fifo_clr) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (wr_en) wptr <= wptr + AW'(1);
         if (pop)   rptr <= rptr + AW'(1);
         unique case ({wr_en, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Registered CPU read data
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s_readdata <= 32'h0;
      end else if (s_read) begin
         unique case (1'b1)
            (s_address == 3'd0): s_readdata <= status;
            (s_address == 3'd1): s_readdata <= empty ? 32'h0 : head[31:0];
            (s_address == 3'd2): s_readdata <= empty ? 32'h0 : head[63:32];
            (s_address == 3'd3): s_readdata <= {29'h0, clr_pend, 1'b0, enable};
            (s_address == 3'd4): s_readdata <= rd_evt;
            default:             s_readdata <= 32'h0;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_perf_sampler.sv
// tb_aes_perf_sampler: randomized bench with a perf-counter slave model
// and a queue-based reference of the sample FIFO and status word.
module tb_aes_perf_sampler;

`ifdef AES_PERF_SAMPLER_EVENT_EN
   localparam bit EV = 1'b1;
   localparam int B  = 4;
`else
   localparam bit EV = 1'b0;
   localparam int B  = 0;
`endif
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        aes_start, aes_done;
   logic [2:0]  m_address;
   logic        m_write, m_begintransfer;
   logic [31:0] m_writedata;
   logic [31:0] m_readdata = 32'h0;
   logic [2:0]  s_address;
   logic        s_read, s_write;
   logic [31:0] s_writedata;
   logic [31:0] s_readdata;

   aes_perf_sampler #(.DEPTH(DEPTH), .CTR_BASE(B)) dut (
      .clk(clk), .reset_n(reset_n),
      .aes_start(aes_start), .aes_done(aes_done),
      .m_address(m_address), .m_write(m_write),
      .m_begintransfer(m_begintransfer), .m_writedata(m_writedata),
      .m_readdata(m_readdata),
      .s_address(s_address), .s_read(s_read), .s_write(s_write),
      .s_writedata(s_writedata), .s_readdata(s_readdata)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;
   logic [95:0] q[$];
   bit ovf = 1'b0;
   int drops = 0, ops_clr = 0, n_ops = 0;

   // Perf-counter slave: B+1 write starts, B write 0 stops, B write 1 clears
   logic [63:0] ctr = 64'h0;
   logic        run = 1'b0;
   logic [31:0] evt = 32'h0;
   always @(posedge clk) begin
      if (m_write && m_address == 3'(B + 1)) begin
         ctr <= 64'h0;
         run <= 1'b1;
         evt <= evt + 1;
      end else if (m_write && m_address == 3'(B)) begin
         run <= 1'b0;
         if (m_writedata == 32'd1) begin
            ctr <= 64'h0;
            evt <= 32'h0;
         end
      end else if (run) begin
         ctr <= ctr + 1;
      end
      if (m_address == 3'(B))          m_readdata <= ctr[31:0];
      else if (m_address == 3'(B + 1)) m_readdata <= ctr[63:32];
      else if (m_address == 3'(B + 2)) m_readdata <= evt;
      else                             m_readdata <= 32'hdead_beef;
   end

   // Bus monitor
   int cyc = 0, go_n = 0, stop_n = 0, clr_n = 0, bad_wr = 0, bt_bad = 0;
   int last_go = 0, last_stop = 0, last_clr = 0;
   logic [7:0] seen = 8'h0;
   always @(negedge clk) begin
      cyc++;
      if (reset_n) begin
         if (m_begintransfer !== m_write) bt_bad++;
         if (m_write) begin
            if (m_address == 3'(B + 1) && m_writedata == 0) begin
               go_n++; last_go = cyc;
            end else if (m_address == 3'(B) && m_writedata == 0) begin
               stop_n++; last_stop = cyc;
            end else if (m_address == 3'(B) && m_writedata == 1) begin
               clr_n++; last_clr = cyc;
            end else begin
               bad_wr++;
            end
         end else begin
            seen[m_address] = 1'b1;
         end
      end
   end

   task automatic check(input string tag, input logic [95:0] got,
                        input logic [95:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_rd(input logic [2:0] a, output logic [31:0] d);
      s_address = a;
      s_read    = 1'b1;
      tick;
      s_read    = 1'b0;
      d         = s_readdata;
   endtask

   task automatic cpu_wr(input logic [2:0] a, input logic [31:0] d);
      s_address   = a;
      s_writedata = d;
      s_write     = 1'b1;
      tick;
      s_write     = 1'b0;
   endtask

   task automatic status_chk(input string tag);
      logic [31:0] d, e;
      cpu_rd(3'd0, d);
      e = {8'h0, 8'(drops), 4'h0, 1'b0, ovf,
           q.size() == DEPTH, q.size() == 0, 8'(q.size())};
      check(tag, d, e);
   endtask

   task automatic pop_chk(input string tag);
      logic [31:0] d;
      logic [95:0] e;
      e = (q.size() == 0) ? 96'h0 : q.pop_front();
      cpu_rd(3'd1, d);
      check({tag, "_lo"}, d, e[31:0]);
      cpu_rd(3'd4, d);
      check({tag, "_evt"}, d, EV ? e[95:64] : 32'h0);
      cpu_rd(3'd2, d);
      check({tag, "_hi"}, d, e[63:32]);
   endtask

   // One AES operation: done arrives dur cycles after start
   task automatic run_op(input int dur, input int ndrop, input int cw,
                         input bit psync, input bit rst);
      int t;
      logic [95:0] s;
      logic [31:0] d;
      ops_clr++;
      n_ops++;
      s = {32'(ops_clr), 32'h0, 32'(dur - 1)};
      aes_start = 1'b1;
      tick;
      aes_start = 1'b0;
      t = 0;
      for (int i = 0; i < ndrop; i++) begin
         tick;
         aes_start = 1'b1;
         tick;
         aes_start = 1'b0;
         t += 2;
      end
      drops = (drops + ndrop > 255) ? 255 : drops + ndrop;
      if (cw >= 0) begin
         cpu_wr(3'd3, 32'(cw));
         t += 1;
      end
      repeat (dur - 1 - t) tick;
      aes_done = 1'b1;
      tick;
      aes_done = 1'b0;
      if (rst) begin
         tick;
         tick;
         reset_n = 1'b0;
         #1;
         check("rst_mid_mwrite", m_write, 0);
         check("rst_mid_mbt", m_begintransfer, 0);
         check("rst_mid_maddr", m_address, 0);
         check("rst_mid_mwdata", m_writedata, 0);
         check("rst_mid_srdata", s_readdata, 0);
         tick;
         reset_n = 1'b1;
         q.delete();
         ovf = 1'b0;
         drops = 0;
         repeat (10) tick;
         return;
      end
      if (psync) begin
         repeat (EV ? 5 : 4) tick;
         cpu_rd(3'd2, d);
         check("sync_pop_hi", d, q[0][63:32]);
         void'(q.pop_front());
      end
      if (q.size() < DEPTH) q.push_back(s);
      else                  ovf = 1'b1;
      if (cw >= 0 && cw[2]) ops_clr = 0;
      repeat (10) tick;
   endtask

   initial begin
      logic [31:0] d;
      logic [95:0] e;
      int clr_at;
      reset_n = 1'b0;
      aes_start = 1'b0;
      aes_done = 1'b0;
      s_address = 3'h0;
      s_read = 1'b0;
      s_write = 1'b0;
      s_writedata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_mwrite", m_write, 0);
      check("rst_mbt", m_begintransfer, 0);
      check("rst_maddr", m_address, 0);
      check("rst_mwdata", m_writedata, 0);
      check("rst_srdata", s_readdata, 0);
      reset_n = 1'b1;
      tick;
      status_chk("rst_status");

      aes_start = 1'b1;
      aes_done  = 1'b1;
      tick;
      aes_start = 1'b0;
      aes_done  = 1'b0;
      repeat (5) tick;
      check("disabled_go", go_n, 0);
      status_chk("disabled_status");

      cpu_wr(3'd3, 32'h1);
      cpu_rd(3'd3, d);
      check("ctrl_readback", d, 32'h1);

      run_op(100, 0, -1, 1'b0, 1'b0);
      check("go_once", go_n, 1);
      check("stop_once", stop_n, 1);
      status_chk("one_status");
      pop_chk("one");
      status_chk("one_drained");

      run_op(40, 3, 0, 1'b0, 1'b0);
      status_chk("drop3_status");
      pop_chk("drop3");
      cpu_wr(3'd3, 32'h1);

      run_op(700, 300, -1, 1'b0, 1'b0);
      status_chk("drop_sat_status");
      cpu_wr(3'd3, 32'h3);
      q.delete();
      ovf = 1'b0;
      drops = 0;
      status_chk("fifo_clr_status");
      pop_chk("empty_rd");
      status_chk("empty_rd_status");

      repeat (9) run_op($urandom_range(5, 30), 0, -1, 1'b0, 1'b0);
      status_chk("ovf_status");
      e = q[0];
      cpu_rd(3'd1, d);
      check("sync_head_lo", d, e[31:0]);
      cpu_rd(3'd4, d);
      check("sync_head_evt", d, EV ? e[95:64] : 32'h0);
      run_op(12, 0, -1, 1'b1, 1'b0);
      status_chk("sync_status");
      repeat (8) pop_chk("ovf_drain");
      status_chk("ovf_empty");
      cpu_wr(3'd3, 32'h3);
      ovf = 1'b0;
      drops = 0;

      run_op(30, 0, 5, 1'b0, 1'b0);
      check("ctr_clr_once", clr_n, 1);
      check("ctr_clr_after_stop", last_clr > last_stop, 1);
      clr_at = last_clr;
      pop_chk("ctr_clr_op");
      run_op(20, 0, -1, 1'b0, 1'b0);
      check("go_after_clr", last_go > clr_at, 1);
      pop_chk("post_clr_op");
      status_chk("post_clr_status");

      for (int i = 0; i < 15; i++) begin
         run_op($urandom_range(8, 40), $urandom_range(0, 2), -1,
                1'b0, 1'b0);
         repeat ($urandom_range(0, 2)) pop_chk("rand");
         status_chk("rand_status");
      end
      repeat (DEPTH) pop_chk("rand_drain");

      run_op(15, 0, -1, 1'b0, 1'b0);
      run_op(25, 0, -1, 1'b0, 1'b1);
      status_chk("rst_mid_status");
      cpu_wr(3'd3, 32'h1);
      run_op(18, 0, -1, 1'b0, 1'b0);
      pop_chk("after_rst");
      status_chk("after_rst_status");

      check("go_total", go_n, n_ops);
      check("stop_total", stop_n, n_ops);
      check("clr_total", clr_n, 1);
      check("bt_matches_write", bt_bad, 0);
      check("legal_writes", bad_wr, 0);
      check("read_addrs", seen & (8'h7 << B),
            EV ? (8'h7 << B) : (8'h3 << B));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
